// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: fetch PC, credit-limited imem requests, fetch queue to decode.
// Optional IF_PERF_CNT_EN adds saturating empty-decode and redirect cycle counters.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_empty_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CAP = FQ_DEPTH[CW:0];

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_os;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_q_pc   [FQ_DEPTH];
  logic [31:0]   r_q_inst [FQ_DEPTH];

  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [CW:0]   w_inflight;
  logic [31:0]   w_redirect_pc;

  assign w_inflight    = {1'b0, r_count} + {1'b0, r_os};
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_empty       = (r_count == '0);

  // Gated by rst_n so no request is presented while the block is held in reset.
  assign imem_req  = rst_n && !redirect_valid && (w_inflight < CAP);
  assign imem_addr = r_pc;
  assign w_issue   = imem_req && imem_gnt;

  assign inst_valid = !w_empty && !redirect_valid;
  assign inst       = w_empty ? NOP_INST  : r_q_inst[r_rd_ptr];
  assign inst_pc    = w_empty ? r_resp_pc : r_q_pc[r_rd_ptr];

  assign w_pop  = inst_valid && inst_ready;
  assign w_push = imem_rvalid && !redirect_valid && (r_drop == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_os      <= '0;
      r_drop    <= '0;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
    end else begin
      r_os <= r_os + CW'(w_issue) - CW'(imem_rvalid);
      if (redirect_valid) begin
        // Every request still outstanding after this cycle belongs to the old path.
        r_pc      <= w_redirect_pc;
        r_resp_pc <= w_redirect_pc;
        r_drop    <= r_os - CW'(imem_rvalid);
        r_count   <= '0;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
      end else begin
        if (w_issue) r_pc <= r_pc + 32'd4;
        if (imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; r_count alone marks which
  // entries are meaningful, and the outputs never expose an entry beyond it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_resp_pc;
      r_q_inst[r_wr_ptr] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_empty_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (inst_ready && !inst_valid && (perf_empty_cnt != '1))
        perf_empty_cnt <= perf_empty_cnt + 32'd1;
      if (redirect_valid && (perf_redirect_cnt != '1))
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus randomized traffic
// against a queue/epoch reference model and a tagged instruction memory.
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_empty_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  if_fetch_queue #(.RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_empty_cnt    (perf_empty_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A granted request remembers its address, the fetch path (epoch) it belongs to,
  // and the cycle it was granted so the response comes at least one cycle later.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          gcyc;
  } req_t;

  req_t        pend[$];
  logic [31:0] fq[$];
  logic [31:0] m_pc;
  int          epoch;
  int          cyc;
  int          first_valid;
  int          m_empty_cnt;
  int          m_redir_cnt;

  int          gnt_mode;   // 0 random, 1 always, 2 never
  int          rv_mode;
  int          rdy_mode;
  logic        redir_now;
  logic [31:0] redir_target;

  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    fq.delete();
    m_pc        = RESET_PC;
    epoch       = 0;
    cyc         = 0;
    first_valid = -1;
    m_empty_cnt = 0;
    m_redir_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    inst_ready     = 1'b0;
    redir_now      = 1'b0;
    #1;
    model_clear();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, NOP_INST);
    check("rst_inst_pc", inst_pc, RESET_PC);
`ifdef IF_PERF_CNT_EN
    check("rst_perf_empty", perf_empty_cnt, 32'd0);
    check("rst_perf_redir", perf_redirect_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    check("rst_hold_imem_req", imem_req, 1'b0);
    check("rst_hold_inst_valid", inst_valid, 1'b0);
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs 1 time unit
  // later, then advance the model to what the coming rising edge must produce.
  // Returns before that edge, so callers may still inspect the current outputs.
  task automatic cycle();
    logic fire_rv;
    logic req_exp;
    logic v_exp;
    req_t r;
    @(negedge clk);
    rst_n          = 1'b1;
    redirect_valid = redir_now;
    redirect_pc    = redir_now ? redir_target : $urandom;
    redir_now      = 1'b0;
    imem_gnt       = pick(gnt_mode);
    inst_ready     = pick(rdy_mode);
    fire_rv        = (pend.size() > 0) && (pend[0].gcyc < cyc) && pick(rv_mode);
    imem_rvalid    = fire_rv;
    imem_rdata     = fire_rv ? mem_word(pend[0].addr) : $urandom;
    #1;

    req_exp = !redirect_valid && ((fq.size() + pend.size()) < DEPTH);
    v_exp   = (fq.size() != 0) && !redirect_valid;
    check("imem_req", imem_req, req_exp);
    if (req_exp) check("imem_addr", imem_addr, m_pc);
    check("inst_valid", inst_valid, v_exp);
    if (fq.size() != 0) begin
      check("inst_pc", inst_pc, fq[0]);
      check("inst", inst, mem_word(fq[0]));
    end else begin
      check("inst_nop", inst, NOP_INST);
    end
`ifdef IF_PERF_CNT_EN
    check("perf_empty_cnt", perf_empty_cnt, m_empty_cnt);
    check("perf_redirect_cnt", perf_redirect_cnt, m_redir_cnt);
`endif
    if (inst_valid && first_valid < 0) first_valid = cyc;

    if (inst_ready && !v_exp) m_empty_cnt++;
    if (redirect_valid) begin
      m_redir_cnt++;
      fq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      epoch++;
      if (fire_rv) void'(pend.pop_front());
    end else begin
      if (v_exp && inst_ready) void'(fq.pop_front());
      if (fire_rv) begin
        r = pend.pop_front();
        if (r.epoch == epoch) fq.push_back(r.addr);
      end
      if (req_exp && imem_gnt) begin
        r.addr  = m_pc;
        r.epoch = epoch;
        r.gcyc  = cyc;
        pend.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    gnt_mode = 1; rv_mode = 1; rdy_mode = 1;
    redir_now = 1'b0; redir_target = '0;

    // Straight-line fetch from RESET_PC with an ideal memory and decode.
    do_reset();
    repeat (12) cycle();
    check("first_valid_cycle", first_valid, 32'd2);

    // Decode stalled: credit caps the requests, then draining resumes fetch.
    rdy_mode = 2;
    repeat (8) cycle();
    check("stall_req_off", imem_req, 1'b0);
    check("stall_valid_on", inst_valid, 1'b1);
    rdy_mode = 1;
    repeat (8) cycle();

    // Grant withheld for three cycles: request must hold its address.
    gnt_mode = 2;
    repeat (3) cycle();
    check("gnt_hold_req", imem_req, 1'b1);
    gnt_mode = 1;
    repeat (6) cycle();

    // Two requests in flight, then a redirect to an unaligned target.
    gnt_mode = 2;
    repeat (6) cycle();
    gnt_mode = 1; rv_mode = 2;
    repeat (2) cycle();
    gnt_mode = 2;
    redir_now = 1'b1; redir_target = 32'h0000_0203;
    cycle();
    check("redir_valid_low", inst_valid, 1'b0);
    cycle();
    check("redir_next_addr", imem_addr, 32'h0000_0200);
    rv_mode = 1; gnt_mode = 1;
    repeat (10) cycle();

    // Redirect coinciding with a response and a pop.
    repeat (4) cycle();
    check("rvpop_pre_valid", inst_valid, 1'b1);
    redir_now = 1'b1; redir_target = 32'h0000_0400;
    cycle();
    check("rvpop_rvalid_in_R", imem_rvalid, 1'b1);
    cycle();
    check("rvpop_empty_R1", inst_valid, 1'b0);
    repeat (8) cycle();

    // Address wrap through 0xFFFF_FFFC.
    redir_now = 1'b1; redir_target = 32'hFFFF_FFF4;
    cycle();
    repeat (12) cycle();

    // Reset in the middle of traffic, then a starved decode.
    gnt_mode = 0; rv_mode = 0; rdy_mode = 0;
    repeat (5) cycle();
    do_reset();
    gnt_mode = 2; rdy_mode = 1;
    repeat (5) cycle();
`ifdef IF_PERF_CNT_EN
    cycle();
    check("perf_empty_five", perf_empty_cnt, 32'd5);
`endif
    gnt_mode = 1; rv_mode = 1;
    repeat (6) cycle();

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 800; i++) begin
      if (i % 16 == 0) begin
        gnt_mode = $urandom_range(0, 1);
        rv_mode  = $urandom_range(0, 1);
        rdy_mode = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 24) == 0) begin
        redir_now    = 1'b1;
        redir_target = $urandom;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
